rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
Arbiter and sequencer for the single write port of REG_File in the Decode stage. It shares that port between two requesters: the pipeline writeback stage (WB), which cannot be back-pressured, and the multi-cycle mul/div unit (MD), which uses a valid/ready handshake. MD results wait in a small in-order queue. A pending-destination scoreboard lets the hazard unit stall readers of registers that still have a result queued.

Parameters:
DEPTH, 2, MD result queue entries (power of two, at least 2)
STARVE_MAX, 3, consecutive cycles an MD result may lose to WB before MD is forced through
AW, 5, register address width
DW, 32, data width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
wb_we  input  1  WB write request
wb_rd  input  AW  WB destination register
wb_data  input  DW  WB write data
md_valid  input  1  MD result valid
md_rd  input  AW  MD destination register
md_data  input  DW  MD result data
md_ready  output  1  queue can accept an MD result
rs  input  AW  Decode source register 1
rt  input  AW  Decode source register 2
rs_pending  output  1  rs matches a queued MD destination
rt_pending  output  1  rt matches a queued MD destination
wb_stall  output  1  WB denied this cycle; pipeline must hold WB inputs unchanged
rf_reg_write  output  1  to REG_File.reg_write
rf_rd  output  AW  to REG_File.rd
rf_write_data  output  DW  to REG_File.write_data

Behaviour:
- Single clock clk; reset is synchronous and active-high.
- Reset state: queue empty, starve counter 0.
  - Outputs after reset: md_ready=1, rs_pending=0, rt_pending=0, wb_stall=0, rf_reg_write=0, rf_rd=0, rf_write_data=0 (outputs are 0 whenever nothing is granted).
  - Reset asserted mid-operation discards all queued results.
- Request qualification:
  - A WB request is wb_we=1 with wb_rd!=0.
  - An MD push is md_valid && md_ready.
  - An MD push with md_rd=0 is accepted and discarded (never enqueued).
- Handshake:
  - md_ready = !full, computed from registered state only. No pop-to-push passthrough when full.
  - MD latency: a result accepted in cycle n is written to the register file no earlier than cycle n+1. The queue is always used; there is no bypass.
- Grant rules (combinational, from registered state plus current inputs):
  - Queue empty: a WB request is granted. Outputs = WB fields, rf_reg_write=1.
  - WB request present, queue non-empty, starve counter < STARVE_MAX: WB is granted and the counter increments.
  - WB request present, queue non-empty, starve counter == STARVE_MAX: the queue head is granted and popped. wb_stall=1 and the counter clears.
  - No WB request, queue non-empty: the queue head is granted and popped. The counter clears.
- States: IDLE (queue empty), DRAIN (queue non-empty, MD owns the port or is waiting), FORCE (counter == STARVE_MAX).
  - IDLE->DRAIN on push.
  - DRAIN->FORCE when the counter reaches STARVE_MAX.
  - FORCE->DRAIN or FORCE->IDLE after the forced pop.
- WAW squash:
  - When a WB write is granted to register r, every queued entry with rd==r is invalidated in the same cycle; the WB value is the youngest.
  - Invalidated entries are popped without a write when they reach the head, and do not count as a grant.
  - If the squash empties the queue's valid entries, the counter clears.
- Scoreboard:
  - rs_pending = (rs!=0) and some valid queued entry has rd==rs. rt_pending is defined the same way for rt.
  - A result being popped in the current cycle still counts as pending.
- Simultaneous push and pop in the same cycle: allowed when not full; occupancy is unchanged. Pointers wrap modulo DEPTH.

Decomposition:
- Shared package holds AW, DW, the state enum (IDLE/DRAIN/FORCE), and the R0 constant.
- Natural sub-module: rf_md_queue. It holds the DEPTH-entry FIFO with per-entry valid bits, rd-match squash, and rs/rt match lookups.
- Arbitration and the starve counter live in the top level.

Test Plan:
- Reset sequence: hold reset for 2 cycles with md_valid=1 -> all outputs 0 except md_ready=1; nothing is enqueued.
- WB only: wb_we=1, wb_rd=5, wb_data=A5A5A5A5 -> same cycle rf_reg_write=1, rf_rd=5, rf_write_data=A5A5A5A5; wb_stall=0.
- MD only: md_valid=1 in cycle n, md_rd=10, md_data=5A5A5A5A -> rt_pending=1 for rt=10 at cycle n+1; write to reg 10 at cycle n+1; pending clears at cycle n+2.
- Starvation: MD result queued, then WB requests every cycle -> WB is granted for 3 cycles; in the 4th cycle wb_stall=1 and the MD entry is written; the held WB is written the next cycle.
- Full and squash:
  - Push 2 MD results (rd=15, rd=7) while WB writes are continuous -> md_ready=0.
  - WB writes rd=15 with 12345678 -> the rd=15 entry is squashed; only rd=7 is later written; rs=15 pending drops to 0 the cycle after the WB write.
- rd=0 handling: wb_rd=0 with wb_we=1, and md_rd=0 -> no rf_reg_write; the queue stays empty.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared widths, register-zero constant and arbiter state encoding for the
// register-file write-port arbiter.
package rf_write_arbiter_pkg;

    localparam int AW = 5;
    localparam int DW = 32;

    localparam logic [AW-1:0] R0 = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rf_md_queue.sv
// In-order queue of mul/div results with per-entry valid bits, same-cycle
// squash by destination register and source-register match lookups.
module rf_md_queue #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [AW-1:0] push_rd,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          squash_en,
    input  logic [AW-1:0] squash_rd,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    output logic          full,
    output logic          empty,
    output logic [PW:0]   level,
    output logic          head_valid,
    output logic [AW-1:0] head_rd,
    output logic [DW-1:0] head_data,
    output logic          valid_left,
    output logic          rs_match,
    output logic          rt_match
);

    logic [DEPTH-1:0] valid_q;
    logic [AW-1:0]    rd_q   [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic [DEPTH-1:0] squash_mask;

    assign level      = count;
    assign full       = (count == (PW+1)'(DEPTH));
    assign empty      = (count == '0);
    assign head_valid = !empty && valid_q[rd_ptr];
    assign head_rd    = rd_q[rd_ptr];
    assign head_data  = data_q[rd_ptr];

    // An entry being popped this cycle is still reported as pending.
    always_comb begin
        squash_mask = '0;
        rs_match    = 1'b0;
        rt_match    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (squash_en && valid_q[i] && (rd_q[i] == squash_rd))
                squash_mask[i] = 1'b1;
            if (valid_q[i] && (rs != '0) && (rd_q[i] == rs))
                rs_match = 1'b1;
            if (valid_q[i] && (rt != '0) && (rd_q[i] == rt))
                rt_match = 1'b1;
        end
    end

    assign valid_left = |(valid_q & ~squash_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            valid_q <= valid_q & ~squash_mask;
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            if (push) begin
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wr_ptr]   <= push_rd;
            data_q[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between the unstallable WB stage
// and queued mul/div results, with starvation forcing and WAW squash.
module rf_write_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 3,
    parameter int AW         = rf_write_arbiter_pkg::AW,
    parameter int DW         = rf_write_arbiter_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    input  logic          md_valid,
    input  logic [AW-1:0] md_rd,
    input  logic [DW-1:0] md_data,
    output logic          md_ready,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    output logic          rs_pending,
    output logic          rt_pending,
    output logic          wb_stall,
    output logic          rf_reg_write,
    output logic [AW-1:0] rf_rd,
    output logic [DW-1:0] rf_write_data
);
    import rf_write_arbiter_pkg::*;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    // Handshake: an MD result transfers on a cycle where md_valid && md_ready;
    // md_ready depends only on registered occupancy, so it never reacts to a
    // same-cycle pop.
    arb_state_t    state;
    arb_state_t    state_next;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] cnt_next;

    logic          q_full, q_empty, head_valid, valid_left;
    logic [PW:0]   q_level;
    logic [PW:0]   level_next;
    logic [AW-1:0] head_rd;
    logic [DW-1:0] head_data;
    logic          wb_req, force_md, md_grant, wb_grant, q_push, q_pop;

    assign wb_req   = wb_we && (wb_rd != R0);
    assign force_md = wb_req && head_valid && (state == FORCE);
    assign md_grant = head_valid && (!wb_req || force_md);
    assign wb_grant = wb_req && !force_md;
    assign md_ready = !q_full;
    assign q_push   = md_valid && md_ready && (md_rd != R0);
    // Squashed entries at the head leave silently without using the port.
    assign q_pop    = !q_empty && (md_grant || !head_valid);
    assign wb_stall = force_md;

    rf_md_queue #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .PW    (PW)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (q_push),
        .push_rd    (md_rd),
        .push_data  (md_data),
        .pop        (q_pop),
        .squash_en  (wb_grant),
        .squash_rd  (wb_rd),
        .rs         (rs),
        .rt         (rt),
        .full       (q_full),
        .empty      (q_empty),
        .level      (q_level),
        .head_valid (head_valid),
        .head_rd    (head_rd),
        .head_data  (head_data),
        .valid_left (valid_left),
        .rs_match   (rs_pending),
        .rt_match   (rt_pending)
    );

    always_comb begin
        rf_reg_write  = 1'b0;
        rf_rd         = '0;
        rf_write_data = '0;
        if (md_grant) begin
            rf_reg_write  = 1'b1;
            rf_rd         = head_rd;
            rf_write_data = head_data;
        end else if (wb_grant) begin
            rf_reg_write  = 1'b1;
            rf_rd         = wb_rd;
            rf_write_data = wb_data;
        end
    end

    // The counter only runs while WB keeps beating a live queued result.
    always_comb begin
        cnt_next = starve_cnt;
        if (!wb_req || md_grant || !valid_left)
            cnt_next = '0;
        else if (starve_cnt != CNT_MAX)
            cnt_next = starve_cnt + 1'b1;

        level_next = q_level + (PW+1)'(q_push) - (PW+1)'(q_pop);
        if (level_next == '0)
            state_next = IDLE;
        else if (cnt_next == CNT_MAX)
            state_next = FORCE;
        else
            state_next = DRAIN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            state      <= IDLE;
        end else begin
            starve_cnt <= cnt_next;
            state      <= state_next;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench: expected register-file writes are queued as stimulus is
// issued and a negedge monitor pops and compares every write the DUT makes.
module tb_rf_write_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          wb_we;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          md_valid;
    logic [AW-1:0] md_rd;
    logic [DW-1:0] md_data;
    logic          md_ready;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          rs_pending;
    logic          rt_pending;
    logic          wb_stall;
    logic          rf_reg_write;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_write_data;

    int vectors    = 0;
    int miscompares = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_exp;

    rf_write_arbiter #(
        .DEPTH      (2),
        .STARVE_MAX (3),
        .AW         (AW),
        .DW         (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wb_we         (wb_we),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .md_valid      (md_valid),
        .md_rd         (md_rd),
        .md_data       (md_data),
        .md_ready      (md_ready),
        .rs            (rs),
        .rt            (rt),
        .rs_pending    (rs_pending),
        .rt_pending    (rt_pending),
        .wb_stall      (wb_stall),
        .rf_reg_write  (rf_reg_write),
        .rf_rd         (rf_rd),
        .rf_write_data (rf_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [AW-1:0] rd, input logic [DW-1:0] data);
        exp_q.push_back({rd, data});
    endtask

    // Monitor: every write must match the oldest expected write; idle cycles
    // must present zero address and data.
    always @(negedge clk) begin
        if (!reset) begin
            if (rf_reg_write) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write",
                             rf_rd, rf_write_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rf_write", {27'd0, rf_rd, rf_write_data}, {27'd0, mon_exp});
                end
            end else begin
                check("idle_outputs", {27'd0, rf_rd, rf_write_data}, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset held two cycles with an MD request present.
        reset = 1'b1; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        md_valid = 1'b1; md_rd = 5'd3; md_data = 32'hDEAD0003; rs = 5'd3; rt = 5'd3;
        step(); step();
        @(negedge clk);
        check("rst_md_ready", md_ready, 1);
        check("rst_rs_pending", rs_pending, 0);
        check("rst_rt_pending", rt_pending, 0);
        check("rst_wb_stall", wb_stall, 0);
        check("rst_reg_write", rf_reg_write, 0);
        check("rst_rd_data", {rf_rd, rf_write_data}, 0);
        reset = 1'b0; md_valid = 1'b0;
        step();
        @(negedge clk);
        check("post_rst_pending", rt_pending, 0);
        check("post_rst_reg_write", rf_reg_write, 0);
        step();

        // WB only: written in the same cycle.
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hA5A5A5A5;
        expect_write(5'd5, 32'hA5A5A5A5);
        @(negedge clk);
        check("wb_only_write", rf_reg_write, 1);
        check("wb_only_stall", wb_stall, 0);
        step();

        // MD only: written and pending the cycle after acceptance.
        wb_we = 1'b0; md_valid = 1'b1; md_rd = 5'd10; md_data = 32'h5A5A5A5A; rt = 5'd10;
        expect_write(5'd10, 32'h5A5A5A5A);
        @(negedge clk);
        check("md_push_ready", md_ready, 1);
        check("md_push_no_write", rf_reg_write, 0);
        check("md_push_not_pending", rt_pending, 0);
        step();
        md_valid = 1'b0;
        @(negedge clk);
        check("md_pending_n1", rt_pending, 1);
        check("md_write_n1", rf_reg_write, 1);
        step();
        @(negedge clk);
        check("md_pending_n2", rt_pending, 0);
        check("md_idle_n2", rf_reg_write, 0);
        step();

        // Starvation: WB wins three times against a queued result, then stalls.
        md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h11112222; rs = 5'd9;
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h00000100;
        expect_write(5'd1, 32'h00000100);
        @(negedge clk);
        check("starve_s0_stall", wb_stall, 0);
        step();
        md_valid = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            wb_rd = AW'(k); wb_data = DW'(k * 256);
            expect_write(AW'(k), DW'(k * 256));
            @(negedge clk);
            check("starve_wb_win_stall", wb_stall, 0);
            check("starve_wb_win_pending", rs_pending, 1);
            step();
        end
        wb_rd = 5'd6; wb_data = 32'h00000600;
        expect_write(5'd9, 32'h11112222);
        expect_write(5'd6, 32'h00000600);
        @(negedge clk);
        check("starve_forced_stall", wb_stall, 1);
        check("starve_forced_pending", rs_pending, 1);
        step();
        @(negedge clk);
        check("starve_held_stall", wb_stall, 0);
        check("starve_held_pending", rs_pending, 0);
        step();

        // Fill the queue behind continuous WB, then squash rd=15 with a WB write.
        wb_rd = 5'd20; wb_data = 32'h00002000;
        md_valid = 1'b1; md_rd = 5'd15; md_data = 32'hAAAA0015; rs = 5'd15; rt = 5'd7;
        expect_write(5'd20, 32'h00002000);
        @(negedge clk);
        check("fill_f0_ready", md_ready, 1);
        step();
        wb_rd = 5'd21; wb_data = 32'h00002100; md_rd = 5'd7; md_data = 32'hBBBB0007;
        expect_write(5'd21, 32'h00002100);
        @(negedge clk);
        check("fill_f1_ready", md_ready, 1);
        check("fill_f1_rs_pending", rs_pending, 1);
        step();
        md_valid = 1'b0; wb_rd = 5'd15; wb_data = 32'h12345678;
        expect_write(5'd15, 32'h12345678);
        @(negedge clk);
        check("full_ready", md_ready, 0);
        check("squash_cycle_rs_pending", rs_pending, 1);
        check("squash_cycle_rt_pending", rt_pending, 1);
        check("squash_cycle_stall", wb_stall, 0);
        step();
        wb_we = 1'b0;
        expect_write(5'd7, 32'hBBBB0007);
        @(negedge clk);
        check("squashed_rs_pending", rs_pending, 0);
        check("squashed_rt_pending", rt_pending, 1);
        check("squashed_head_no_write", rf_reg_write, 0);
        check("squashed_head_ready", md_ready, 0);
        step();
        @(negedge clk);
        check("survivor_write", rf_reg_write, 1);
        check("survivor_pending", rt_pending, 1);
        check("survivor_ready", md_ready, 1);
        step();
        @(negedge clk);
        check("drained_pending", rt_pending, 0);
        check("drained_ready", md_ready, 1);
        step();

        // Register zero: neither requester produces a write or an entry.
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF0000;
        md_valid = 1'b1; md_rd = 5'd0; md_data = 32'hEEEE0000; rs = 5'd0; rt = 5'd0;
        @(negedge clk);
        check("r0_no_write", rf_reg_write, 0);
        check("r0_ready", md_ready, 1);
        check("r0_stall", wb_stall, 0);
        step();
        wb_we = 1'b0; md_valid = 1'b0;
        @(negedge clk);
        check("r0_not_enqueued", rf_reg_write, 0);
        check("r0_ready_after", md_ready, 1);
        step();

        // Reset while a result is queued discards it.
        md_valid = 1'b1; md_rd = 5'd12; md_data = 32'h0000000C; rt = 5'd12;
        @(negedge clk);
        check("midrst_push_no_write", rf_reg_write, 0);
        step();
        md_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_pending", rt_pending, 0);
        check("midrst_no_write", rf_reg_write, 0);
        check("midrst_ready", md_ready, 1);
        step();

        repeat (3) step();
        check("exp_q_drained", 64'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
